// File: rtl/lighthouse_emitter.sv
// lighthouse_emitter: two-station lighthouse sync/sync/sweep pulse generator on an active-low pin.
// Define LIGHTHOUSE_EMITTER_RANGE_CHECK_EN to suppress out-of-range sweeps and flag angle_error.
module lighthouse_emitter #(
  parameter int CLOCKS_PER_MICROSECOND = 48,
  parameter int PERIOD = 400000,
  parameter int SYNC_GAP = 19200,
  parameter int SWEEP_LEN = 480,
  parameter int SYNC_UNIT = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [19:0] angle0,
  input  logic [19:0] angle1,
  input  logic [19:0] angle2,
  input  logic [19:0] angle3,
  input  logic [1:0]  ootx,
  output logic        pin,
  output logic        frame_strobe,
  output logic [1:0]  frame_index,
  output logic        ootx_strobe,
  output logic        angle_error,
  output logic        busy
);
  localparam logic [2:0] IDLE = 3'd0, SYNC0 = 3'd1, GAP0 = 3'd2, SYNC1 = 3'd3, WAIT = 3'd4, SWEEP = 3'd5, TAIL = 3'd6;
  localparam logic [20:0] LAST = 21'(PERIOD - 1);
  localparam logic [20:0] GAP = 21'(SYNC_GAP);
  localparam logic [20:0] LEN = 21'(SWEEP_LEN);
  localparam logic [20:0] HALF = 21'(SWEEP_LEN / 2);
  localparam logic [20:0] UNIT = 21'(SYNC_UNIT);
  if (SWEEP_LEN >= 15 * CLOCKS_PER_MICROSECOND) begin : g_sweep_len_check
    $error("SWEEP_LEN must be shorter than 15 us");
  end
  logic [2:0]  state, state_n, ty0, ty1;
  logic [19:0] t, ang;
  logic [1:0]  ootx_l, f_n;
  logic [20:0] tn, a21, l0, l1, r, s_start, s_end;
  logic        last, start, cont, valid, err_n;
  always_comb begin
    ty0 = {frame_index[1], ootx_l[0], ~frame_index[0]};
    ty1 = {~frame_index[1], ootx_l[1], ~frame_index[0]};
    l0 = UNIT * (21'd6 + 21'(ty0));
    l1 = UNIT * (21'd6 + 21'(ty1));
    r = GAP + l1;
    a21 = {1'b0, ang};
    s_start = a21 < HALF ? r + 21'd1 : r + a21 - HALF;
    s_end = s_start + LEN;
`ifdef LIGHTHOUSE_EMITTER_RANGE_CHECK_EN
    valid = a21 >= LEN && r + a21 + HALF <= LAST;
`else
    valid = 1'b1;
`endif
    tn = {1'b0, t} + 21'd1;
    last = {1'b0, t} == LAST;
    start = enable && (state == IDLE || last);
    cont = state != IDLE && !last;
    f_n = state == IDLE ? 2'd0 : frame_index + 2'd1;
    err_n = cont && tn == r && !valid;
    // Sweep is clipped so the final cycle of the frame is always high.
    state_n = start ? SYNC0 : !cont ? IDLE : tn < l0 ? SYNC0 : tn < GAP ? GAP0 : tn < r ? SYNC1 :
              !valid ? TAIL : tn < s_start ? WAIT : (tn < s_end && tn < LAST) ? SWEEP : TAIL;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      t <= '0;
      ang <= '0;
      ootx_l <= '0;
      frame_index <= '0;
      pin <= 1'b1;
      frame_strobe <= 1'b0;
      ootx_strobe <= 1'b0;
      angle_error <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      t <= cont && !start ? tn[19:0] : '0;
      frame_index <= start ? f_n : cont ? frame_index : 2'd0;
      if (start) ang <= f_n[1] ? (f_n[0] ? angle3 : angle2) : (f_n[0] ? angle1 : angle0);
      if (start) ootx_l <= ootx;
      pin <= !(state_n == SYNC0 || state_n == SYNC1 || state_n == SWEEP);
      frame_strobe <= start;
      ootx_strobe <= start;
`ifdef LIGHTHOUSE_EMITTER_RANGE_CHECK_EN
      angle_error <= err_n;
`else
      angle_error <= 1'b0 & err_n;
`endif
      busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_lighthouse_emitter.sv
// tb_lighthouse_emitter: directed pulse-timing checks with scaled-down frame parameters.
module tb_lighthouse_emitter;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [19:0] angle0 = 20'd300, angle1 = 20'd500, angle2 = 20'd5, angle3 = 20'd800;
  logic [1:0] ootx = 2'b00;
  logic pin, frame_strobe, ootx_strobe, angle_error, busy;
  logic [1:0] frame_index;
  int cyc = 0, checks = 0, errors = 0, t0;
  int falls[$], lens[$], strobes[$], ostr[$], aerr[$], idxs[$];
  int ef[$], el[$], es[$], ei[$], ea[$];
  bit rec = 1'b0, prev = 1'b1;

  lighthouse_emitter #(.CLOCKS_PER_MICROSECOND(48), .PERIOD(2000), .SYNC_GAP(400), .SWEEP_LEN(40), .SYNC_UNIT(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .angle0(angle0), .angle1(angle1), .angle2(angle2), .angle3(angle3), .ootx(ootx),
    .pin(pin), .frame_strobe(frame_strobe), .frame_index(frame_index),
    .ootx_strobe(ootx_strobe), .angle_error(angle_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rec) begin
      if (!pin && prev) falls.push_back(cyc);
      if (pin && !prev && falls.size() > 0) lens.push_back(cyc - falls[$]);
      if (frame_strobe) begin
        strobes.push_back(cyc);
        idxs.push_back(int'(frame_index));
      end
      if (ootx_strobe) ostr.push_back(cyc);
      if (angle_error) aerr.push_back(cyc);
    end
    prev = pin;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input int got[$], input int exp[$], input int base);
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) check($sformatf("%s[%0d]", tag, i), got[i] - base, exp[i]);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic clear_q();
    falls.delete(); lens.delete(); strobes.delete(); ostr.delete(); aerr.delete(); idxs.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_pin", pin, 1);
    check("rst_busy", busy, 0);
    check("rst_fstrobe", frame_strobe, 0);
    check("rst_index", frame_index, 0);
    reset = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    check("presync_pin", pin, 0);
    reset = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("midrst_pin", pin, 1);
    check("midrst_fstrobe", frame_strobe, 0);
    check("midrst_ostrobe", ootx_strobe, 0);
    check("midrst_aerr", angle_error, 0);
    check("midrst_busy", busy, 0);
    check("midrst_index", frame_index, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    // four-frame rotation plus one wrap, enable dropped mid-way through the fifth frame
    rec = 1'b1;
    enable = 1'b1;
    t0 = cyc + 1;
    wait_cyc(t0 + 10);
    ootx = 2'b11;
    wait_cyc(t0 + 9000);
    enable = 1'b0;
    wait_cyc(t0 + 9999);
    check("lastcyc_busy", busy, 1);
    check("lastcyc_pin", pin, 1);
    @(negedge clk);
    check("end_busy", busy, 0);
    check("end_index", frame_index, 0);
    wait_cyc(t0 + 10100);
    rec = 1'b0;
`ifdef LIGHTHOUSE_EMITTER_RANGE_CHECK_EN
    ef = '{0, 400, 856, 2000, 2400, 3072, 4000, 4400, 6000, 6400, 7308, 8000, 8400, 8888};
    el = '{112, 176, 40, 128, 192, 40, 208, 144, 192, 128, 40, 144, 208, 40};
    ea = '{4544};
`else
    ef = '{0, 400, 856, 2000, 2400, 3072, 4000, 4400, 4545, 6000, 6400, 7308, 8000, 8400, 8888};
    el = '{112, 176, 40, 128, 192, 40, 208, 144, 40, 192, 128, 40, 144, 208, 40};
    ea = '{};
`endif
    es = '{0, 2000, 4000, 6000, 8000};
    ei = '{0, 1, 2, 3, 0};
    cmp_q("falls", falls, ef, t0);
    cmp_q("lens", lens, el, 0);
    cmp_q("fstrobe", strobes, es, t0);
    cmp_q("ostrobe", ostr, es, t0);
    cmp_q("index", idxs, ei, 0);
    cmp_q("aerr", aerr, ea, t0);
    // sweep window running past the frame end
    clear_q();
    angle0 = 20'd1380;
    rec = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    t0 = cyc + 1;
    wait_cyc(t0 + 10);
    enable = 1'b0;
    wait_cyc(t0 + 1999);
    check("late_lastpin", pin, 1);
    check("late_lastbusy", busy, 1);
    @(negedge clk);
    check("late_endbusy", busy, 0);
    wait_cyc(t0 + 2100);
    rec = 1'b0;
`ifdef LIGHTHOUSE_EMITTER_RANGE_CHECK_EN
    ef = '{0, 400};
    el = '{144, 208};
    ea = '{608};
`else
    ef = '{0, 400, 1968};
    el = '{144, 208, 31};
    ea = '{};
`endif
    es = '{0};
    cmp_q("late_falls", falls, ef, t0);
    cmp_q("late_lens", lens, el, 0);
    cmp_q("late_fstrobe", strobes, es, t0);
    cmp_q("late_aerr", aerr, ea, t0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lighthouse_emitter.md
# lighthouse_emitter

Lighthouse base-station pulse generator: produces the active-low optical-sensor waveform from two base stations (sync0, sync1, sweep) with chosen angles and OOTX bits. It is the transmit end of the sensor pulse protocol, driving the sensor input pin in loopback benches and on hardware test fixtures. Frames repeat in a fixed four-frame rotation covering both stations and both axes.

## Interface
- `CLOCKS_PER_MICROSECOND`, 48, clock rate, informational; all lengths below are in clocks
- `PERIOD`, 400000, frame length in clocks, max 2^20-1
- `SYNC_GAP`, 19200, sync0 falling edge to sync1 falling edge
- `SWEEP_LEN`, 480, sweep pulse low time, even, < 15 µs
- `SYNC_UNIT`, 512, sync length quantum
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low reset
- `enable`  in  1  run frames while high
- `angle0`..`angle3`  in  20 each  sweep times: station0 axis1, station0 axis0, station1 axis1, station1 axis0
- `ootx`  in  2  OOTX data bit per station ([0] station0, [1] station1)
- `pin`  out  1  sensor waveform, idle high, pulses low
- `frame_strobe`  out  1  one-cycle pulse at each frame start
- `frame_index`  out  2  current frame 0..3
- `ootx_strobe`  out  1  one-cycle pulse when `ootx` is sampled
- `angle_error`  out  1  one-cycle pulse when a sweep is suppressed
- `busy`  out  1  high while a frame is in progress

## Operation
- States: IDLE, SYNC0, GAP0, SYNC1, WAIT, SWEEP, TAIL; 20-bit frame timer `t` counts from 0 at frame start.
- Frame f: station s = f[1]; axis a = !f[0]. Frames 0..3 sweep angle0..angle3 respectively.
- At frame start (t=0): latch angle[f] and `ootx`, pulse `frame_strobe` and `ootx_strobe`.
- Sync code per pulse k (k=0 station0, k=1 station1): type_k = {skip_k, ootx[k], a}, skip_k = (k != s). Low length L_k = (6 + type_k) × SYNC_UNIT.
- SYNC0: pin low for t in [0, L0). GAP0: high until t = SYNC_GAP. SYNC1: low for L1 clocks; rising edge at R = SYNC_GAP + L1.
- WAIT: high until t = R + angle − SWEEP_LEN/2. SWEEP: low for SWEEP_LEN clocks (midpoint exactly R + angle). TAIL: high until t = PERIOD−1.
- At t = PERIOD−1: if `enable`, next cycle begins frame (f+1) mod 4; else return to IDLE, `frame_index` reset to 0.
- IDLE → frame 0 on the cycle after `enable` is seen high.
- `enable` falling mid-frame: current frame completes, no truncation.
- Arithmetic: 21-bit intermediates for R + angle ± SWEEP_LEN/2; no wrap.
- Reset values: `pin`=1, `frame_strobe`=0, `ootx_strobe`=0, `angle_error`=0, `busy`=0, `frame_index`=0, state IDLE. Reset mid-pulse forces `pin` high next cycle.

## Timing
- All outputs registered. `enable` high sampled at cycle N → `pin` falls, `frame_strobe`/`ootx_strobe` high at N+1.
- Angle and `ootx` changes after frame start take effect the next frame.
- Sweep window valid iff angle ≥ SWEEP_LEN and R + angle + SWEEP_LEN/2 ≤ PERIOD−1.
- `angle_error` pulses at t = R (sync1 rising edge).
- Frame-to-frame: sync0 falls exactly PERIOD clocks after the previous sync0 fall.

## Configuration
- `LIGHTHOUSE_EMITTER_RANGE_CHECK_EN` defined: invalid sweep window → no sweep pulse, pin stays high to frame end, `angle_error` pulses.
- Not defined: `angle_error` tied 0; sweep always scheduled. An angle below SWEEP_LEN/2 starts the sweep at R+1. Any sweep running past PERIOD−1 is forced high at frame end.

## Test plan
- Reset low with `pin` low mid-sync → `pin`=1 next cycle, all strobes 0, `busy`=0, `frame_index`=0.
- Defaults, `ootx`=0, angle0=4096, enable at N → sync0 low 3584 clocks from N+1. Sync1 falls at N+1+19200 and is low 5632 clocks. Sweep low from N+1+24832+3856 for 480 clocks.
- Four consecutive frames, `ootx`=2'b11 → sync lengths (units of 512): frame0 9/13, frame1 8/12, frame2 13/9, frame3 12/8. `frame_index` 0,1,2,3,0.
- Loopback into the sensor receiver, angles 0x01000/0x02000/0x03000/0x04000 → receiver reports the same four angles, ±1 clock.
- RANGE_CHECK_EN, angle2=100 → no sweep in frame 2, one `angle_error` pulse at sync1 rise. Without the macro → sweep starts at R+1.
- `enable` dropped at t=1000 of frame 1 → frame 1 completes, `busy` falls at frame end, no frame 2 `frame_strobe`.
